// File: rtl/conv_pkg.sv
// Shared widths for the convolution line-buffer pipeline.
package conv_pkg;
  localparam int PIXEL_W = 8;
endpackage

// File: rtl/conv_lb_if.sv
// Pixel stream, line-buffer control and delayed column-marker bundle for conv_lb_seq.
interface conv_lb_if #(
  parameter int LB_N    = 3,
  parameter int PIXEL_W = conv_pkg::PIXEL_W
);
  localparam int PTR_W = $clog2(LB_N);

  logic               in_vld;
  logic               in_rdy;
  logic [PIXEL_W-1:0] in_dat;
  logic               in_sof;
  logic               in_sol;
  logic               in_eol;
  logic               in_eof;

  logic [LB_N-1:0]    lb_push_o;
  logic [LB_N-1:0]    lb_pop_o;
  logic [PIXEL_W-1:0] lb_dat_o;
  logic               lb_sol_o;
  logic               lb_eol_o;

  logic               out_vld;
  logic               out_sol;
  logic               out_eol;
  logic [PIXEL_W-1:0] out_dat;
  logic [LB_N-2:0]    out_rows_vld;
  logic [PTR_W-1:0]   out_oldest;
  logic               err_o;

  modport master (
    output in_vld, in_dat, in_sof, in_sol, in_eol, in_eof,
    input  in_rdy, lb_push_o, lb_pop_o, lb_dat_o, lb_sol_o, lb_eol_o,
    input  out_vld, out_sol, out_eol, out_dat, out_rows_vld, out_oldest, err_o
  );

  modport slave (
    input  in_vld, in_dat, in_sof, in_sol, in_eol, in_eof,
    output in_rdy, lb_push_o, lb_pop_o, lb_dat_o, lb_sol_o, lb_eol_o,
    output out_vld, out_sol, out_eol, out_dat, out_rows_vld, out_oldest, err_o
  );
endinterface

// File: rtl/conv_lb_seq.sv
// Line-buffer sequencer: rotates push target per line, pops the buffers holding
// valid older rows, and delays beat markers to line up with buffer read data.
module conv_lb_seq #(
  parameter int LB_N   = 3,
  parameter int RD_LAT = 2
) (
  input logic      clk,
  input logic      rst,
  conv_lb_if.slave bus
);
  localparam int PIXEL_W = conv_pkg::PIXEL_W;
  localparam int PTR_W   = $clog2(LB_N);
  localparam int ROWS    = LB_N - 1;

  typedef enum logic [1:0] {IDLE, LINE, GAP} state_t;

  typedef struct packed {
    logic               vld;
    logic               sol;
    logic               eol;
    logic [PIXEL_W-1:0] dat;
    logic [ROWS-1:0]    rows_vld;
    logic [PTR_W-1:0]   oldest;
  } stage_t;

  state_t           state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] lines_q, lines_d;
  logic             err_q, err_d;
  stage_t           pipe_q [RD_LAT];
  stage_t           pipe_d [RD_LAT];

  logic             in_rdy;
  logic             beat;
  logic             accept;
  logic [PTR_W-1:0] cur_ptr, cur_lines;
  logic [LB_N-1:0]  push, pop;
  stage_t           new_stage;

  // Buffer i is (ptr-1-i) mod LB_N lines old; only rows written this frame are popped.
  function automatic logic [LB_N-1:0] pop_mask(input logic [PTR_W-1:0] ptr,
                                               input logic [PTR_W-1:0] lines);
    logic [LB_N-1:0] m;
    int              age;
    m = '0;
    for (int i = 0; i < LB_N; i++) begin
      age = (int'(ptr) + 2 * LB_N - 1 - i) % LB_N;
      if (i != int'(ptr) && age < int'(lines)) m[i] = 1'b1;
    end
    return m;
  endfunction

  function automatic logic [ROWS-1:0] rows_mask(input logic [PTR_W-1:0] lines);
    logic [ROWS-1:0] m;
    m = '0;
    for (int j = 0; j < ROWS; j++) m[j] = (j >= ROWS - int'(lines));
    return m;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (int'(ptr) == LB_N - 1) ? '0 : ptr + 1'b1;
  endfunction

  assign in_rdy = (state_q != GAP);
  assign beat   = bus.in_vld & in_rdy & ~rst;

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    lines_d   = lines_q;
    err_d     = err_q;
    accept    = 1'b0;
    cur_ptr   = wr_ptr_q;
    cur_lines = lines_q;
    push      = '0;
    pop       = '0;
    new_stage = '0;

    case (state_q)
      IDLE: if (beat) begin
        if (bus.in_sof && bus.in_sol) begin
          accept    = 1'b1;
          cur_ptr   = '0;
          cur_lines = '0;
        end else begin
          err_d = 1'b1;
        end
      end
      LINE: if (beat) begin
        accept = 1'b1;
        // A stray sof restarts the frame on this very beat.
        if (bus.in_sof) begin
          err_d     = 1'b1;
          cur_ptr   = '0;
          cur_lines = '0;
        end else if (bus.in_sol) begin
          err_d = 1'b1;
        end
      end
      GAP:     state_d = LINE;
      default: state_d = IDLE;
    endcase

    if (accept) begin
      if (bus.in_eof && !bus.in_eol) err_d = 1'b1;
      push               = LB_N'(1) << cur_ptr;
      pop                = pop_mask(cur_ptr, cur_lines);
      new_stage.vld      = 1'b1;
      new_stage.sol      = bus.in_sol;
      new_stage.eol      = bus.in_eol;
      new_stage.dat      = bus.in_dat;
      new_stage.rows_vld = rows_mask(cur_lines);
      new_stage.oldest   = (int'(cur_lines) == ROWS) ? ptr_inc(cur_ptr) : '0;
      wr_ptr_d           = cur_ptr;
      lines_d            = cur_lines;
      state_d            = LINE;
      if (bus.in_eol) begin
        wr_ptr_d = ptr_inc(cur_ptr);
        lines_d  = (int'(cur_lines) == ROWS) ? cur_lines : cur_lines + 1'b1;
        state_d  = bus.in_eof ? IDLE : GAP;
      end
    end

    pipe_d[0] = new_stage;
    for (int k = 1; k < RD_LAT; k++) pipe_d[k] = pipe_q[k-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      lines_q  <= '0;
      err_q    <= 1'b0;
      for (int k = 0; k < RD_LAT; k++) pipe_q[k] <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      lines_q  <= lines_d;
      err_q    <= err_d;
      pipe_q   <= pipe_d;
    end
  end

  assign bus.in_rdy       = in_rdy;
  assign bus.lb_push_o    = push;
  assign bus.lb_pop_o     = pop;
  assign bus.lb_dat_o     = bus.in_dat;
  assign bus.lb_sol_o     = bus.in_sol;
  assign bus.lb_eol_o     = bus.in_eol;
  assign bus.out_vld      = pipe_q[RD_LAT-1].vld;
  assign bus.out_sol      = pipe_q[RD_LAT-1].sol;
  assign bus.out_eol      = pipe_q[RD_LAT-1].eol;
  assign bus.out_dat      = pipe_q[RD_LAT-1].dat;
  assign bus.out_rows_vld = pipe_q[RD_LAT-1].rows_vld;
  assign bus.out_oldest   = pipe_q[RD_LAT-1].oldest;
  assign bus.err_o        = err_q;
endmodule
